pixel_pack_fsm: RTL
===================

PIXEL_PACK_FSM -- requirements
Module: pixel_pack_fsm

Interface
REQ-001 SHALL have parameter PIX_BITS, default 1: bits kept per pixel; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter WORD_W, default 8: packed word width; legal values 8, 16, 32; WORD_W % PIX_BITS == 0.
REQ-003 SHALL have parameter FRAME_PIXELS, default 40800: pixels per frame.
REQ-004 SHALL have parameter MSB_FIRST, default 0: slot order (0 = first pixel in the low bits).
REQ-005 SHALL have derived localparams PPW = WORD_W/PIX_BITS, WORDS = ceil(FRAME_PIXELS/PPW) and ADDR_W = $clog2(WORDS).
REQ-006 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port pix_de, input, 1 bit: pixel valid.
REQ-009 SHALL have port pix_sof, input, 1 bit: start of frame, qualified by pix_de.
REQ-010 SHALL have port pix_data, input, 8 bits: pixel; only [PIX_BITS-1:0] is used.
REQ-011 SHALL have port we, output, 1 bit: one-cycle RAM write strobe.
REQ-012 SHALL have port wData, output, WORD_W bits: packed word.
REQ-013 SHALL have port wAddr, output, ADDR_W bits: word address.
REQ-014 SHALL have port frame_tick, output, 1 bit: one-cycle end-of-frame pulse.
REQ-015 SHALL have port sof_err, output, 1 bit: one-cycle pulse when pix_sof arrives mid-frame.

Function
REQ-016 SHALL accept a pixel on every cycle with pix_de=1, in every state, with no backpressure and no dropped pixels.
REQ-017 SHALL write pixel slot s (0..PPW-1) to accumulator bits [s*PIX_BITS +: PIX_BITS] when MSB_FIRST=0, and to [(PPW-1-s)*PIX_BITS +: PIX_BITS] when MSB_FIRST=1.
REQ-018 SHALL, when slot PPW-1 is accepted at cycle t, drive we=1 at t+1 with wData = completed word and wAddr = current word index.
REQ-019 SHALL, in that same step, clear the accumulator and wrap the slot counter to 0.
REQ-020 SHALL place a pixel accepted at t+1 into slot 0 of the next word, so back-to-back pixels need no gap.
REQ-021 SHALL increment the word index after each write; wAddr holds its value between writes.
REQ-022 SHALL, when pixel FRAME_PIXELS-1 is accepted at t, write the final word at t+1 with unused slots zero-padded.
REQ-023 SHALL assert frame_tick in the same cycle as that final we.
REQ-024 SHALL, at the final write of REQ-022, reset the word index and the frame pixel counter to 0.
REQ-025 SHALL implement states ST_IDLE (no pixel of current frame yet), ST_FILL (frame in progress) and ST_DONE (the frame_tick cycle).
REQ-026 SHALL transition IDLE->FILL on pix_de, FILL->DONE on the last frame pixel, and DONE->IDLE, except DONE->FILL when pix_de=1 in the DONE cycle.
REQ-027 SHALL, on pix_sof=1 with pix_de=1 while in FILL, discard the partial word with no write, set word index to 0, pulse sof_err and treat that pixel as pixel 0.
REQ-028 SHALL treat pix_sof in IDLE or DONE as a normal frame start with no error.
REQ-029 SHALL use a word-index counter that never exceeds WORDS-1 and never wraps within a frame.

Reset
REQ-030 SHALL, while reset_n=0 at a clock edge, force state ST_IDLE and set we, frame_tick and sof_err to 0, wData, wAddr, accumulator, slot and pixel counters to 0, and edge_count to 0 when present.
REQ-031 SHALL, on reset mid-word or mid-frame, drop the partial data silently; the first pixel after release is pixel 0, word 0.

Configuration
REQ-032 SHALL, with PIXEL_PACK_STATS_EN defined, add output edge_count [$clog2(FRAME_PIXELS+1)-1:0] giving the number of pixels with pix_data[0]=1 in the last completed frame, updated in the frame_tick cycle.
REQ-033 SHALL, with PIXEL_PACK_STATS_EN defined, zero the running count on sof_err.
REQ-034 SHALL, without PIXEL_PACK_STATS_EN, omit the edge_count port and its counter logic, with all other behaviour unchanged.

Structure
REQ-035 SHALL place the state enum type and the legal PIX_BITS/WORD_W checks (elaboration-time assertions) in shared package pixel_pack_pkg.
REQ-036 SHALL be a single module with no sub-module; the packing datapath is inline.

Verification
REQ-037 SHALL cover: PIX_BITS=1, WORD_W=8, MSB_FIRST=0, pixels 1,0,1,1,0,0,0,1 -> we one cycle after the 8th pixel, wData=8'h8D, wAddr=0.
REQ-038 SHALL cover: the same stimulus with MSB_FIRST=1 -> wData=8'hB1.
REQ-039 SHALL cover: FRAME_PIXELS=12, WORD_W=8, 12 pixels of 1 -> writes 8'hFF@0 then 8'h0F@1, frame_tick with the second write, edge_count=12 (STATS_EN).
REQ-040 SHALL cover: PIX_BITS=4, WORD_W=16, continuous pix_de across the frame boundary -> no pixel lost, next frame starts at wAddr=0, frame_tick exactly once per frame.
REQ-041 SHALL cover: pix_sof on pixel 5 of word 3 -> sof_err pulses 1 cycle, no write for the partial word, next write at wAddr=0.
REQ-042 SHALL cover: reset_n low for 1 cycle after 3 pixels -> all outputs 0, following 8 pixels produce a single write at wAddr=0.

Source files
------------

// File: rtl/pixel_pack_pkg.sv
// Shared types and configuration checks for the pixel packer.
// The state enum and the PIX_BITS/WORD_W legality rules live here so every user agrees on them.
package pixel_pack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } pixel_pack_state_e;

  function automatic bit pix_bits_legal(input int pix_bits);
    return (pix_bits == 1) || (pix_bits == 2) || (pix_bits == 4) || (pix_bits == 8);
  endfunction

  function automatic bit word_w_legal(input int word_w, input int pix_bits);
    return ((word_w == 8) || (word_w == 16) || (word_w == 32)) && ((word_w % pix_bits) == 0);
  endfunction

  // Counter widths must stay at least one bit even when the range collapses to a single value.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/pixel_pack_fsm.sv
// Packs a pixel stream into fixed-width RAM words, one write per completed word, with frame tracking.
// Optional feature: define PIXEL_PACK_STATS_EN to add the edge_count statistics output.
module pixel_pack_fsm
  import pixel_pack_pkg::*;
#(
  parameter int PIX_BITS     = 1,
  parameter int WORD_W       = 8,
  parameter int FRAME_PIXELS = 40800,
  parameter int MSB_FIRST    = 0,
  localparam int PPW         = WORD_W / PIX_BITS,
  localparam int WORDS       = (FRAME_PIXELS + PPW - 1) / PPW,
  localparam int ADDR_W      = clog2_min1(WORDS),
  localparam int EDGE_W      = $clog2(FRAME_PIXELS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_de,
  input  logic              pix_sof,
  input  logic [7:0]        pix_data,
  output logic              we,
  output logic [WORD_W-1:0] wData,
  output logic [ADDR_W-1:0] wAddr,
  output logic              frame_tick,
`ifdef PIXEL_PACK_STATS_EN
  output logic [EDGE_W-1:0] edge_count,
`endif
  output logic              sof_err
);

  localparam int SLOT_W = clog2_min1(PPW);
  localparam int PCNT_W = clog2_min1(FRAME_PIXELS);

  if (!pix_bits_legal(PIX_BITS) || !word_w_legal(WORD_W, PIX_BITS)) begin : g_bad_cfg
    $error("pixel_pack_fsm: illegal PIX_BITS/WORD_W combination");
  end

  pixel_pack_state_e state_r, state_nxt_s;

  logic [SLOT_W-1:0] slot_r, slot_nxt_s, slot_s, lane_s;
  logic [WORD_W-1:0] acc_r, acc_nxt_s, acc_in_s, acc_ins_s, wdata_nxt_s;
  logic [ADDR_W-1:0] word_idx_r, word_idx_nxt_s, wi_s, waddr_nxt_s;
  logic [PCNT_W-1:0] pix_cnt_r, pix_cnt_nxt_s, idx_s;
  logic              restart_s, last_pix_s, word_end_s;
  logic              we_nxt_s, tick_nxt_s, err_nxt_s;
  logic              unused_pix_s;

  assign unused_pix_s = ^pix_data;

  // Mid-frame SOF restarts the frame: the current pixel is rebased onto slot 0 of word 0.
  always_comb begin
    restart_s  = pix_de && pix_sof && (state_r == ST_FILL);
    idx_s      = restart_s ? '0 : pix_cnt_r;
    slot_s     = restart_s ? '0 : slot_r;
    wi_s       = restart_s ? '0 : word_idx_r;
    acc_in_s   = restart_s ? '0 : acc_r;
    last_pix_s = (idx_s == PCNT_W'(FRAME_PIXELS - 1));
    word_end_s = (slot_s == SLOT_W'(PPW - 1)) || last_pix_s;
    if (MSB_FIRST != 0) begin
      lane_s = SLOT_W'(PPW - 1) - slot_s;
    end else begin
      lane_s = slot_s;
    end
    acc_ins_s = acc_in_s;
    acc_ins_s[int'(lane_s) * PIX_BITS +: PIX_BITS] = pix_data[PIX_BITS-1:0];
  end

  // Frame state: DONE marks the frame_tick cycle and may roll straight into the next frame.
  always_comb begin
    state_nxt_s = state_r;
    if (pix_de) begin
      if (last_pix_s) begin
        state_nxt_s = ST_DONE;
      end else begin
        state_nxt_s = ST_FILL;
      end
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_FILL: state_nxt_s = ST_FILL;
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Packing datapath: completed words leave as a registered write and the accumulator clears.
  always_comb begin
    slot_nxt_s     = slot_r;
    acc_nxt_s      = acc_r;
    word_idx_nxt_s = word_idx_r;
    pix_cnt_nxt_s  = pix_cnt_r;
    we_nxt_s       = 1'b0;
    wdata_nxt_s    = wData;
    waddr_nxt_s    = wAddr;
    tick_nxt_s     = 1'b0;
    err_nxt_s      = 1'b0;
    if (pix_de) begin
      err_nxt_s = restart_s;
      if (last_pix_s) begin
        pix_cnt_nxt_s = '0;
      end else begin
        pix_cnt_nxt_s = idx_s + PCNT_W'(1);
      end
      if (word_end_s) begin
        we_nxt_s    = 1'b1;
        wdata_nxt_s = acc_ins_s;
        waddr_nxt_s = wi_s;
        acc_nxt_s   = '0;
        slot_nxt_s  = '0;
        tick_nxt_s  = last_pix_s;
        if (last_pix_s) begin
          word_idx_nxt_s = '0;
        end else begin
          word_idx_nxt_s = wi_s + ADDR_W'(1);
        end
      end else begin
        acc_nxt_s      = acc_ins_s;
        slot_nxt_s     = slot_s + SLOT_W'(1);
        word_idx_nxt_s = wi_s;
      end
    end else begin
      err_nxt_s = 1'b0;
    end
  end

`ifdef PIXEL_PACK_STATS_EN
  logic [EDGE_W-1:0] run_cnt_r, run_cnt_nxt_s, run_sum_s, edge_nxt_s;

  // Count pixels with bit 0 set; the running total restarts with the frame.
  always_comb begin
    run_cnt_nxt_s = run_cnt_r;
    edge_nxt_s    = edge_count;
    run_sum_s     = (restart_s ? '0 : run_cnt_r) + EDGE_W'(pix_data[0]);
    if (pix_de) begin
      if (last_pix_s) begin
        edge_nxt_s    = run_sum_s;
        run_cnt_nxt_s = '0;
      end else begin
        run_cnt_nxt_s = run_sum_s;
      end
    end else begin
      run_cnt_nxt_s = run_cnt_r;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_cnt_r  <= '0;
      edge_count <= '0;
    end else begin
      run_cnt_r  <= run_cnt_nxt_s;
      edge_count <= edge_nxt_s;
    end
  end
`endif

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      slot_r     <= '0;
      acc_r      <= '0;
      word_idx_r <= '0;
      pix_cnt_r  <= '0;
      we         <= 1'b0;
      wData      <= '0;
      wAddr      <= '0;
      frame_tick <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      slot_r     <= slot_nxt_s;
      acc_r      <= acc_nxt_s;
      word_idx_r <= word_idx_nxt_s;
      pix_cnt_r  <= pix_cnt_nxt_s;
      we         <= we_nxt_s;
      wData      <= wdata_nxt_s;
      wAddr      <= waddr_nxt_s;
      frame_tick <= tick_nxt_s;
      sof_err    <= err_nxt_s;
    end
  end

endmodule
